// File: rtl/ct_vfdsu_norm_ctrl.sv
// Operand normalization sequencer for the vector FP divide/sqrt unit.
// Shares one external leading-one/normalize unit between src0 and src1 over up to two cycles.
module ct_vfdsu_norm_ctrl #(
  parameter int FRAC_W = 52,
  parameter int EXP_W  = 13
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              ctrl_norm_flush,
  input  logic              start_vld,
  output logic              start_rdy,
  input  logic [FRAC_W-1:0] src0_frac,
  input  logic [FRAC_W-1:0] src1_frac,
  input  logic [EXP_W-1:0]  src0_exp,
  input  logic [EXP_W-1:0]  src1_exp,
  input  logic              src0_denorm,
  input  logic              src1_denorm,
  output logic [FRAC_W-1:0] ff1_frac_num,
  input  logic [FRAC_W-1:0] ff1_shift_num,
  input  logic [EXP_W-1:0]  ff1_bin_val,
  output logic              norm_vld,
  input  logic              norm_rdy,
  output logic [FRAC_W-1:0] norm_src0_frac,
  output logic [FRAC_W-1:0] norm_src1_frac,
  output logic [EXP_W-1:0]  norm_src0_exp,
  output logic [EXP_W-1:0]  norm_src1_exp,
  output logic              norm_src0_zero,
  output logic              norm_src1_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, NORM0, NORM1, DONE} state_t;

  // Bin value the normalizer reports for an all-zero fraction (-52).
  localparam logic [EXP_W-1:0] ZERO_BIN = 13'h1fcc;

  state_t state, state_nxt;

  logic [FRAC_W-1:0] s0_frac, s1_frac;
  logic [EXP_W-1:0]  s0_exp, s1_exp;
  logic              s0_den, s1_den;
  logic              s0_zero, s1_zero;
  logic              accept;

  // Handshakes: a transfer happens on a clock edge where valid and ready are both high
  // (and no flush); valid holds its payload stable until then.
  assign start_rdy = (state == IDLE);
  assign accept    = start_vld & start_rdy & ~ctrl_norm_flush;
  assign norm_vld  = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ff1_frac_num = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (src0_denorm)      state_nxt = NORM0;
          else if (src1_denorm) state_nxt = NORM1;
          else                  state_nxt = DONE;
        end
      end
      NORM0: begin
        ff1_frac_num = s0_frac;
        state_nxt    = s1_den ? NORM1 : DONE;
      end
      NORM1: begin
        ff1_frac_num = s1_frac;
        state_nxt    = DONE;
      end
      DONE: begin
        if (norm_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Flush outranks everything, including a coincident accept or DONE handshake.
    if (ctrl_norm_flush) state_nxt = IDLE;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      s0_frac <= '0;
      s1_frac <= '0;
      s0_exp  <= '0;
      s1_exp  <= '0;
      s0_den  <= 1'b0;
      s1_den  <= 1'b0;
      s0_zero <= 1'b0;
      s1_zero <= 1'b0;
    end else if (accept) begin
      s0_frac <= src0_frac;
      s1_frac <= src1_frac;
      s0_exp  <= src0_exp;
      s1_exp  <= src1_exp;
      s0_den  <= src0_denorm;
      s1_den  <= src1_denorm;
      s0_zero <= 1'b0;
      s1_zero <= 1'b0;
    end else if (!ctrl_norm_flush) begin
      // Exponent adjust wraps modulo 2^EXP_W; underflow is handled downstream.
      if (state == NORM0) begin
        s0_frac <= ff1_shift_num;
        s0_exp  <= s0_exp + ff1_bin_val;
        s0_zero <= (ff1_bin_val == ZERO_BIN);
      end else if (state == NORM1) begin
        s1_frac <= ff1_shift_num;
        s1_exp  <= s1_exp + ff1_bin_val;
        s1_zero <= (ff1_bin_val == ZERO_BIN);
      end
    end
  end

  assign norm_src0_frac = s0_frac;
  assign norm_src1_frac = s1_frac;
  assign norm_src0_exp  = s0_exp;
  assign norm_src1_exp  = s1_exp;
  assign norm_src0_zero = s0_zero;
  assign norm_src1_zero = s1_zero;

endmodule

// File: tb/tb_ct_vfdsu_norm_ctrl.sv
// Directed bench for ct_vfdsu_norm_ctrl with a behavioural leading-one normalizer model.
module tb_ct_vfdsu_norm_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        flush;
  logic        start_vld;
  logic        start_rdy;
  logic [51:0] src0_frac, src1_frac;
  logic [12:0] src0_exp, src1_exp;
  logic        src0_denorm, src1_denorm;
  logic [51:0] ff1_frac_num;
  logic [51:0] ff1_shift_num;
  logic [12:0] ff1_bin_val;
  logic        norm_vld;
  logic        norm_rdy;
  logic [51:0] n0_frac, n1_frac;
  logic [12:0] n0_exp, n1_exp;
  logic        n0_zero, n1_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [51:0] hold0_frac, hold1_frac;
  logic [12:0] hold0_exp, hold1_exp;

  always #5 clk = ~clk;

  ct_vfdsu_norm_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .ctrl_norm_flush(flush),
    .start_vld      (start_vld),
    .start_rdy      (start_rdy),
    .src0_frac      (src0_frac),
    .src1_frac      (src1_frac),
    .src0_exp       (src0_exp),
    .src1_exp       (src1_exp),
    .src0_denorm    (src0_denorm),
    .src1_denorm    (src1_denorm),
    .ff1_frac_num   (ff1_frac_num),
    .ff1_shift_num  (ff1_shift_num),
    .ff1_bin_val    (ff1_bin_val),
    .norm_vld       (norm_vld),
    .norm_rdy       (norm_rdy),
    .norm_src0_frac (n0_frac),
    .norm_src1_frac (n1_frac),
    .norm_src0_exp  (n0_exp),
    .norm_src1_exp  (n1_exp),
    .norm_src0_zero (n0_zero),
    .norm_src1_zero (n1_zero),
    .busy           (busy)
  );

  // Shared normalizer: shift leading one to bit 51, report -shift; zero input gives -52.
  always_comb begin
    ff1_shift_num = '0;
    ff1_bin_val   = 13'h1fcc;
    for (int i = 0; i < 52; i++) begin
      if (ff1_frac_num[i]) begin
        ff1_shift_num = ff1_frac_num << (51 - i);
        ff1_bin_val   = 13'(i - 51);
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkf(input string tag, input logic [51:0] obs, input logic [51:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chke(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pair(input logic [51:0] f0, input logic [12:0] e0, input logic d0,
                            input logic [51:0] f1, input logic [12:0] e1, input logic d1);
    src0_frac = f0; src0_exp = e0; src0_denorm = d0;
    src1_frac = f1; src1_exp = e1; src1_denorm = d1;
    start_vld = 1'b1;
  endtask

  initial begin
    rst_b = 1'b0; flush = 1'b0; start_vld = 1'b0; norm_rdy = 1'b0;
    src0_frac = '0; src1_frac = '0; src0_exp = '0; src1_exp = '0;
    src0_denorm = 1'b0; src1_denorm = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_vld", norm_vld, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_start_rdy", start_rdy, 1'b1);
    chkf("rst_frac0", n0_frac, 52'h0);
    chke("rst_exp1", n1_exp, 13'h0);
    rst_b = 1'b1;

    // Both normal: one-cycle latency, normalizer never used.
    @(negedge clk);
    drive_pair(52'h8000000000000, 13'h3ff, 1'b0, 52'h8000000000000, 13'h3ff, 1'b0);
    chkf("t1_ff1_idle", ff1_frac_num, 52'h0);
    @(negedge clk);
    start_vld = 1'b0;
    chk1("t1_vld", norm_vld, 1'b1);
    chk1("t1_start_rdy", start_rdy, 1'b0);
    chkf("t1_ff1_done", ff1_frac_num, 52'h0);
    chkf("t1_frac0", n0_frac, 52'h8000000000000);
    chkf("t1_frac1", n1_frac, 52'h8000000000000);
    chke("t1_exp0", n0_exp, 13'h3ff);
    chke("t1_exp1", n1_exp, 13'h3ff);
    chk1("t1_zero0", n0_zero, 1'b0);
    chk1("t1_zero1", n1_zero, 1'b0);
    norm_rdy = 1'b1;
    @(negedge clk);
    chk1("t1_idle_vld", norm_vld, 1'b0);
    chk1("t1_idle_rdy", start_rdy, 1'b1);
    norm_rdy = 1'b0;

    // Both denormal: NORM0 then NORM1 then DONE.
    drive_pair(52'h0000000000001, 13'h001, 1'b1, 52'h4000000000000, 13'h001, 1'b1);
    @(negedge clk);
    start_vld = 1'b0;
    chkf("t2_ff1_norm0", ff1_frac_num, 52'h0000000000001);
    chk1("t2_vld_n0", norm_vld, 1'b0);
    chk1("t2_busy", busy, 1'b1);
    @(negedge clk);
    chkf("t2_ff1_norm1", ff1_frac_num, 52'h4000000000000);
    chk1("t2_vld_n1", norm_vld, 1'b0);
    @(negedge clk);
    chk1("t2_vld", norm_vld, 1'b1);
    chkf("t2_frac0", n0_frac, 52'h8000000000000);
    chke("t2_exp0", n0_exp, 13'h1fce);
    chkf("t2_frac1", n1_frac, 52'h8000000000000);
    chke("t2_exp1", n1_exp, 13'h0000);
    chk1("t2_zero0", n0_zero, 1'b0);
    chk1("t2_zero1", n1_zero, 1'b0);

    // Backpressure in DONE with a different pair held on start_vld.
    drive_pair(52'h123456789abcd, 13'h0400, 1'b0, 52'hfedcba9876543, 13'h0123, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("t4_hold_vld", norm_vld, 1'b1);
      chk1("t4_hold_start_rdy", start_rdy, 1'b0);
      chkf("t4_hold_frac0", n0_frac, 52'h8000000000000);
      chke("t4_hold_exp0", n0_exp, 13'h1fce);
      chke("t4_hold_exp1", n1_exp, 13'h0000);
    end
    norm_rdy = 1'b1;
    @(negedge clk);
    chk1("t4_release_vld", norm_vld, 1'b0);
    chk1("t4_release_rdy", start_rdy, 1'b1);
    norm_rdy = 1'b0;
    @(negedge clk);
    start_vld = 1'b0;
    chk1("t4_new_vld", norm_vld, 1'b1);
    chkf("t4_new_frac0", n0_frac, 52'h123456789abcd);
    chkf("t4_new_frac1", n1_frac, 52'hfedcba9876543);
    chke("t4_new_exp0", n0_exp, 13'h0400);
    chke("t4_new_exp1", n1_exp, 13'h0123);
    norm_rdy = 1'b1;
    @(negedge clk);
    norm_rdy = 1'b0;

    // Zero denormal on src1 only.
    drive_pair(52'h8000000000000, 13'h3ff, 1'b0, 52'h0, 13'h001, 1'b1);
    @(negedge clk);
    start_vld = 1'b0;
    chk1("t3_vld_n1", norm_vld, 1'b0);
    chkf("t3_ff1_norm1", ff1_frac_num, 52'h0);
    @(negedge clk);
    chk1("t3_vld", norm_vld, 1'b1);
    chke("t3_exp1", n1_exp, 13'h1fcd);
    chk1("t3_zero1", n1_zero, 1'b1);
    chk1("t3_zero0", n0_zero, 1'b0);
    chkf("t3_frac0", n0_frac, 52'h8000000000000);
    chke("t3_exp0", n0_exp, 13'h3ff);
    norm_rdy = 1'b1;
    @(negedge clk);
    norm_rdy = 1'b0;

    // Flush while in NORM1.
    drive_pair(52'h0000000000003, 13'h010, 1'b1, 52'h0000000000100, 13'h020, 1'b1);
    @(negedge clk);
    start_vld = 1'b0;
    @(negedge clk);
    chkf("t5_in_norm1", ff1_frac_num, 52'h0000000000100);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk1("t5_flush_busy", busy, 1'b0);
    chk1("t5_flush_vld", norm_vld, 1'b0);
    chk1("t5_flush_rdy", start_rdy, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk1("t5_no_vld", norm_vld, 1'b0);
    end
    // Flush coincident with start in IDLE blocks the accept.
    drive_pair(52'h8000000000000, 13'h3ff, 1'b0, 52'h8000000000000, 13'h3ff, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    start_vld = 1'b0;
    flush = 1'b0;
    chk1("t5_start_flush_busy", busy, 1'b0);
    chk1("t5_start_flush_vld", norm_vld, 1'b0);

    // Reset while waiting in DONE.
    drive_pair(52'h8000000000000, 13'h3ff, 1'b0, 52'h8000000000000, 13'h3ff, 1'b0);
    @(negedge clk);
    start_vld = 1'b0;
    chk1("t6_pre_vld", norm_vld, 1'b1);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    chk1("t6_vld", norm_vld, 1'b0);
    chk1("t6_start_rdy", start_rdy, 1'b1);
    chk1("t6_busy", busy, 1'b0);
    chkf("t6_frac0", n0_frac, 52'h0);
    chkf("t6_frac1", n1_frac, 52'h0);
    chke("t6_exp0", n0_exp, 13'h0);
    chke("t6_exp1", n1_exp, 13'h0);
    chk1("t6_zero0", n0_zero, 1'b0);
    chk1("t6_zero1", n1_zero, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_vfdsu_norm_ctrl.md
Name: ct_vfdsu_norm_ctrl

Overview:
Sequencing controller in front of the vector FP divide/sqrt unit that normalizes denormal operands before iteration. It shares one external 52-bit leading-one/normalize unit between the two source operands (src0 = dividend/radicand, src1 = divisor), time-multiplexing it over up to two cycles. It adjusts each exponent by the returned bin value and hands normalized operands to the iteration stage over a valid/ready handshake.

Parameters:
FRAC_W, 52, fraction width; must match the shared normalizer. Only the default is supported or verified.
EXP_W, 13, exponent/adjust width in two's complement. Only the default is supported or verified.

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  reset, synchronous, active-low
ctrl_norm_flush  in  1  kill the in-flight operation
start_vld  in  1  operand pair valid
start_rdy  out  1  controller can accept a new operand pair
src0_frac / src1_frac  in  52  operand fractions, hidden-bit position at bit 51
src0_exp / src1_exp  in  13  operand effective exponents
src0_denorm / src1_denorm  in  1  operand needs normalization
ff1_frac_num  out  52  fraction driven to the shared normalizer
ff1_shift_num  in  52  normalized fraction returned by the normalizer, same cycle
ff1_bin_val  in  13  exponent adjust returned: 0 down to -51; 0x1fcc (-52) for a zero input
norm_vld  out  1  normalized pair valid
norm_rdy  in  1  downstream accepts the pair
norm_src0_frac / norm_src1_frac  out  52  normalized fractions
norm_src0_exp / norm_src1_exp  out  13  adjusted exponents
norm_src0_zero / norm_src1_zero  out  1  denormal operand fraction was all-zero
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, NORM0, NORM1, DONE. The state is one-hot or encoded; it is not visible at the ports.
- Reset (cpurst_b=0 at a clock edge): state=IDLE; norm_vld=0; all norm_* data and zero flags=0; busy=0; the internal operand registers are cleared.
- start_rdy = (state==IDLE), combinational.
- Accept: start_vld & start_rdy & !ctrl_norm_flush.
  - On accept, capture src0_* and src1_* including the denorm flags into the operand registers.
  - Next state on accept: NORM0 if src0_denorm; else NORM1 if src1_denorm; else DONE.
- ff1_frac_num is driven combinationally from the captured registers:
  - NORM0: captured src0 fraction.
  - NORM1: captured src1 fraction.
  - All other states: 52'b0.
- NORM0 (one cycle):
  - Register src0 fraction <= ff1_shift_num.
  - Register src0 exponent <= exp + ff1_bin_val, modulo 2^13 with no saturation.
  - norm_src0_zero <= (ff1_bin_val==0x1fcc).
  - Next state: NORM1 if the captured src1_denorm is set, else DONE.
- NORM1 (one cycle): same update as NORM0 for src1; next state is DONE.
- A non-denormal operand passes through unchanged and its zero flag is 0.
- DONE: norm_vld=1. All norm_* outputs come from the registers and are stable while norm_vld & !norm_rdy. On norm_rdy the next state is IDLE.
- No new operand pair is accepted in the same cycle as the DONE handshake. Minimum initiation interval is 2 cycles.
- Latency from the accept edge to norm_vld: 1 cycle with no denormals, 2 cycles with one, 3 cycles with both.
- ctrl_norm_flush has priority over every other event in every state:
  - Next state is IDLE and norm_vld deasserts on the next cycle.
  - Registered data is left as is.
  - A start_vld in the same cycle as a flush is not accepted.
- A flush in DONE coinciding with norm_rdy counts as a flush. Downstream must qualify the transfer with its own flush.
- The exponent adjust is purely additive. Underflow handling belongs to the downstream stage.

Test Plan:
1. Both normal: src0_frac=0x8000000000000, src0_exp=0x3ff, src1 identical, start at cycle T → norm_vld=1 at T+1, outputs equal the inputs, ff1_frac_num stays 0 throughout, zero flags 0.
2. Both denormal: src0_frac=0x0000000000001, src0_exp=1; src1_frac=0x4000000000000, src1_exp=1 → ff1_frac_num=0x1 at T+1 and 0x4000000000000 at T+2. norm_vld at T+3 with norm_src0_frac=0x8000000000000, norm_src0_exp=0x1fce, norm_src1_frac=0x8000000000000, norm_src1_exp=0x0000.
3. Zero denormal on src1 only: src1_frac=0, src1_exp=1, src1_denorm=1, src0 normal → NORM1 only, norm_vld at T+2, norm_src1_exp=0x1fcd, norm_src1_zero=1, norm_src0_zero=0.
4. Backpressure: norm_rdy=0 for 5 cycles in DONE → all outputs bit-stable, start_rdy=0, a held start_vld is ignored. Then norm_rdy=1 → IDLE next cycle, start_rdy=1, new pair accepted the cycle after.
5. Flush: assert ctrl_norm_flush in NORM1 → IDLE next cycle, norm_vld never asserts. Flush together with start_vld in IDLE → no accept, busy stays 0.
6. Reset mid-operation: cpurst_b=0 for one cycle while in DONE with norm_rdy=0 → next cycle norm_vld=0, all norm_* outputs 0, start_rdy=1.
